// File: rtl/disp_scan.sv
// disp_scan - binary-to-BCD converter and multiplexed digit scanner feeding
// the vending-machine 7-segment decoder.
//
// Ports:
//   clk_i    system clock
//   rst_i    synchronous reset, active-high
//   value_i  binary amount to display (DATA_W bits)
//   load_i   one-cycle strobe: capture value_i and start a conversion
//   digit_o  BCD digit for the decoder input (registered)
//   sel_o    active-low digit enables, one cycle behind digit_o
//   busy_o   conversion in progress
//   ovf_o    last committed value did not fit in NUM_DIGITS digits
module disp_scan #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_W-1:0]     value_i,
    input  logic                  load_i,
    output logic [3:0]            digit_o,
    output logic [NUM_DIGITS-1:0] sel_o,
    output logic                  busy_o,
    output logic                  ovf_o
);

    localparam int unsigned ACC_W = (NUM_DIGITS + 1) * 4;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned PRE_W = $clog2(SCAN_DIV);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0]          bin_q;
    logic [ACC_W-1:0]           bcd_q;
    logic [ACC_W-1:0]           bcd_adj;
    logic [CNT_W-1:0]           cnt_q;
    logic                       ovf_pend_q;
    logic [NUM_DIGITS-1:0][3:0] disp_q;
    logic [NUM_DIGITS-1:0][3:0] commit_val;

    logic [PRE_W-1:0]           presc_q;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           idx_d_q;
    logic                       scan_vld_q;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_i) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q != IDLE);

    // Double-dabble add-3 correction applied before each shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i <= NUM_DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        commit_val = bcd_q[NUM_DIGITS*4-1:0];
        if (ovf_pend_q) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                commit_val[i] = 4'd9;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            disp_q     <= '0;
            ovf_o      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_i) begin
                        bin_q      <= value_i;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        ovf_pend_q <= (64'(value_i) >= LIMIT);
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[ACC_W-2:0], bin_q[DATA_W-1]};
                    bin_q <= {bin_q[DATA_W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                COMMIT: begin
                    disp_q <= commit_val;
                    ovf_o  <= ovf_pend_q;
                end
                default: ;
            endcase
        end
    end

    // ---------------- digit scanner ----------------
    // sel_o is fed from a one-stage-delayed index so it trails digit_o by the
    // decoder's register stage; scan_vld_q keeps sel_o dark for that first stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            idx_q      <= '0;
            idx_d_q    <= '0;
            scan_vld_q <= 1'b0;
            digit_o    <= '0;
            sel_o      <= '1;
        end else begin
            if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            digit_o    <= disp_q[idx_q];
            idx_d_q    <= idx_q;
            scan_vld_q <= 1'b1;
            sel_o      <= scan_vld_q ? ~(NUM_DIGITS'(1) << idx_d_q) : '1;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan - directed self-checking bench for disp_scan with a short
// scan period; expected digit/select pairs go through a scoreboard queue.
module tb_disp_scan;

    localparam int unsigned ND  = 4;
    localparam int unsigned DW  = 14;
    localparam int unsigned DIV = 4;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [DW-1:0] value_i;
    logic          load_i;
    logic [3:0]    digit_o;
    logic [ND-1:0] sel_o;
    logic          busy_o;
    logic          ovf_o;

    typedef struct {
        logic [3:0]    digit;
        logic [ND-1:0] sel;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    disp_scan #(.NUM_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(DIV)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .value_i(value_i),
        .load_i (load_i),
        .digit_o(digit_o),
        .sel_o  (sel_o),
        .busy_o (busy_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge: pulses load_i, then measures busy_o length.
    task automatic do_load(input logic [DW-1:0] v, input bit intrude);
        int cnt;
        value_i = v;
        load_i  = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        cnt = 0;
        while (busy_o && cnt < 100) begin
            cnt++;
            if (intrude && cnt == 3) begin
                value_i = DW'(555);
                load_i  = 1'b1;
            end else begin
                load_i = 1'b0;
            end
            @(negedge clk);
        end
        load_i = 1'b0;
        check("busy_len", 32'(cnt), 32'd15);
    endtask

    // Waits for a fresh digit-0 slot and walks one full scan rotation.
    task automatic check_display(input logic [15:0] bcd, input logic ovf);
        logic [ND-1:0] prev;
        bit            found;
        int            n;
        exp_t          e;
        for (int i = 0; i < ND; i++) begin
            sb.push_back('{digit: bcd[i*4 +: 4], sel: ~(ND'(1) << i)});
        end
        @(negedge clk);
        prev  = sel_o;
        found = 0;
        n     = 0;
        while (!found && n < 40) begin
            @(negedge clk);
            n++;
            if (sel_o == 4'b1110 && prev != 4'b1110) found = 1;
            prev = sel_o;
        end
        check("slot0_found", 32'(found), 32'd1);
        check("ovf", 32'(ovf_o), 32'(ovf));
        for (int i = 0; i < ND; i++) begin
            e = sb.pop_front();
            check("digit", 32'(digit_o), 32'(e.digit));
            check("sel", 32'(sel_o), 32'(e.sel));
            repeat (DIV - 1) @(negedge clk);
            // last cycle of the slot: select unchanged, digit already advanced
            check("sel_hold", 32'(sel_o), 32'(e.sel));
            check("digit_lead", 32'(digit_o), 32'(bcd[((i + 1) % ND) * 4 +: 4]));
            @(negedge clk);
        end
    endtask

    initial begin
        rst_i   = 1'b1;
        load_i  = 1'b1;
        value_i = DW'(1234);
        repeat (3) @(negedge clk);
        check("rst_digit", 32'(digit_o), 32'd0);
        check("rst_sel", 32'(sel_o), 32'hF);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        load_i = 1'b0;
        rst_i  = 1'b0;
        @(negedge clk);
        check("rel_sel1", 32'(sel_o), 32'hF);
        check("rel_digit1", 32'(digit_o), 32'd0);
        @(negedge clk);
        check("rel_sel2", 32'(sel_o), 32'hE);
        check_display(16'h0000, 1'b0);

        do_load(DW'(1234), 0);
        check_display(16'h1234, 1'b0);
        do_load(DW'(9999), 0);
        check_display(16'h9999, 1'b0);
        do_load(DW'(0), 0);
        check_display(16'h0000, 1'b0);
        do_load(DW'(12000), 0);
        check_display(16'h9999, 1'b1);
        do_load(DW'(57), 0);
        check_display(16'h0057, 1'b0);
        do_load(DW'(1234), 1);
        check_display(16'h1234, 1'b0);
        do_load(DW'(12000), 0);
        check_display(16'h9999, 1'b1);

        // Reset during the fifth SHIFT cycle.
        value_i = DW'(1234);
        load_i  = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("mid_rst_digit", 32'(digit_o), 32'd0);
        check("mid_rst_sel", 32'(sel_o), 32'hF);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_ovf", 32'(ovf_o), 32'd0);
        rst_i = 1'b0;
        do_load(DW'(42), 0);
        check_display(16'h0042, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
